cola_fifo_param: RTL

//  Parametrised circular FIFO driven by board-level wr/rd controls (switches/buttons).

---
 rtl/cola_fifo_param.sv | 134 +++++++++++++
 1 files changed

// File: rtl/cola_fifo_param.sv
// Circular FIFO between board switches/buttons and LEDs, with occupancy flags and sticky errors.
// Latency: pushed word visible on salida the cycle after the accepting edge; head is fall-through.
// Backpressure: none; push while full (without pop) and pop while empty are dropped and flagged.
module cola_fifo_param #(
    parameter int DATA_W    = 3,
    parameter int ADDR_W    = 2,
    parameter int EDGE_MODE = 1,
    parameter int AF_LEVEL  = 3,
    parameter int AE_LEVEL  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr,
    input  logic              rd,
    input  logic [DATA_W-1:0] sw,
    input  logic              err_clr,
    output logic [DATA_W-1:0] salida,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [ADDR_W:0]   count,
    output logic              overflow,
    output logic              underflow,
    output logic              error,
    output logic              push,
    output logic              pop,
    output logic [ADDR_W-1:0] w_ptr_reg,
    output logic [ADDR_W-1:0] r_ptr_reg
);

    localparam int              DEPTH   = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_C    = (ADDR_W + 1)'(AF_LEVEL);
    localparam logic [ADDR_W:0] AE_C    = (ADDR_W + 1)'(AE_LEVEL);

    logic                wr_req;
    logic                rd_req;
    logic [ADDR_W-1:0]   w_ptr_q, w_ptr_d;
    logic [ADDR_W-1:0]   r_ptr_q, r_ptr_d;
    logic [ADDR_W:0]     count_q, count_d;
    logic                overflow_q, overflow_d;
    logic                underflow_q, underflow_d;
    logic [DATA_W-1:0]   mem_q [DEPTH];

    // A held button yields one request per press in edge mode.
    generate
        if (EDGE_MODE != 0) begin : g_edge
            logic wr_q, wr_d;
            logic rd_q, rd_d;

            always_comb begin
                wr_d = wr;
                rd_d = rd;
            end

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    wr_q <= 1'b0;
                    rd_q <= 1'b0;
                end else begin
                    wr_q <= wr_d;
                    rd_q <= rd_d;
                end
            end

            assign wr_req = wr & ~wr_q;
            assign rd_req = rd & ~rd_q;
        end else begin : g_level
            assign wr_req = wr;
            assign rd_req = rd;
        end
    endgenerate

    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);

    // A pop frees the slot, so a full FIFO can still take a push in the same cycle.
    assign pop  = rd_req & ~empty;
    assign push = wr_req & (~full | pop);

    always_comb begin
        w_ptr_d     = w_ptr_q;
        r_ptr_d     = r_ptr_q;
        count_d     = count_q;
        if (push) begin
            w_ptr_d = w_ptr_q + ADDR_W'(1);
        end
        if (pop) begin
            r_ptr_d = r_ptr_q + ADDR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + (ADDR_W + 1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (ADDR_W + 1)'(1);
        end
        // A fresh error in the clearing cycle keeps the flag set.
        overflow_d  = (overflow_q & ~err_clr) | (wr_req & ~push);
        underflow_d = (underflow_q & ~err_clr) | (rd_req & empty);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_ptr_q     <= '0;
            r_ptr_q     <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            w_ptr_q     <= w_ptr_d;
            r_ptr_q     <= r_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[w_ptr_q] <= sw;
        end
    end

    assign salida    = empty ? '0 : mem_q[r_ptr_q];
    assign count     = count_q;
    assign overflow  = overflow_q;
    assign underflow = underflow_q;
    assign error     = overflow_q | underflow_q;
    assign w_ptr_reg = w_ptr_q;
    assign r_ptr_reg = r_ptr_q;

endmodule
